// File: rtl/bird_bitmap_loader_pkg.sv
// Shared types and constants for the bird sprite bitmap loader.
package bird_bitmap_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} loader_state_t;
  localparam int RLE_FLAG_BIT = 7;
  localparam int RUN_LEN_W    = 7;
endpackage

// File: rtl/bird_bitmap_loader_if.sv
// Byte-stream input handshake plus the RAM write port driven by the loader.
interface bird_bitmap_loader_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 3
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr_w;
  logic [DATA_WIDTH-1:0] din;

  modport master (output rx_data, rx_valid, input rx_ready, we, addr_w, din);
  modport slave  (input rx_data, rx_valid, output rx_ready, we, addr_w, din);
endinterface

// File: rtl/bird_bitmap_loader.sv
// RLE byte-stream decoder writing one sprite frame to the bitmap RAM from address 0.
module bird_bitmap_loader
  import bird_bitmap_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  bird_bitmap_loader_if.slave  bus,
  output logic                 busy,
  output logic                 done
);
  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] FRAME = {1'b1, {ADDR_WIDTH{1'b0}}};

  generate
    if (DATA_WIDTH < 1 || DATA_WIDTH > 7) begin : g_bad_width
      $error("bird_bitmap_loader: DATA_WIDTH must be in 1..7");
    end
  endgenerate

  loader_state_t         state, state_n;
  logic [PTR_W-1:0]      ptr, ptr_n;
  logic [DATA_WIDTH-1:0] last_pix, last_n;
  logic [RUN_LEN_W:0]    run_cnt, cnt_n;
  logic                  we_q, we_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [DATA_WIDTH-1:0] din_q, din_n;
  logic                  ready, xfer;
  logic [DATA_WIDTH-1:0] lit;

  // Abort gates ready so a byte is never consumed in the cycle the load is dropped.
  assign ready = (state == LOAD) && (ptr != FRAME) && !abort;
  assign xfer  = ready && bus.rx_valid;
  assign lit   = bus.rx_data[DATA_WIDTH-1:0];

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    last_n  = last_pix;
    cnt_n   = run_cnt;
    we_n    = 1'b0;
    addr_n  = addr_q;
    din_n   = din_q;
    case (state)
      IDLE: if (start && !abort) begin
        state_n = LOAD;
        ptr_n   = '0;
      end
      LOAD: begin
        if (abort)              state_n = IDLE;
        else if (ptr == FRAME)  state_n = DONE;
        else if (xfer) begin
          if (bus.rx_data[RLE_FLAG_BIT]) begin
            state_n = RUN;
            cnt_n   = {1'b0, bus.rx_data[RUN_LEN_W-1:0]} + 1'b1;
          end else begin
            we_n   = 1'b1;
            addr_n = ptr[ADDR_WIDTH-1:0];
            din_n  = lit;
            last_n = lit;
            ptr_n  = ptr + 1'b1;
          end
        end
      end
      RUN: begin
        // Reaching the frame end cuts the run short; the pointer never wraps.
        if (abort)              state_n = IDLE;
        else if (ptr == FRAME)  state_n = DONE;
        else begin
          we_n   = 1'b1;
          addr_n = ptr[ADDR_WIDTH-1:0];
          din_n  = last_pix;
          ptr_n  = ptr + 1'b1;
          cnt_n  = run_cnt - 1'b1;
          if (run_cnt == 1) state_n = LOAD;
        end
      end
      DONE: if (start && !abort) begin
        state_n = LOAD;
        ptr_n   = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      last_pix <= '0;
      run_cnt  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      last_pix <= last_n;
      run_cnt  <= cnt_n;
      we_q     <= we_n;
      addr_q   <= addr_n;
      din_q    <= din_n;
    end
  end

  assign bus.rx_ready = ready;
  assign bus.we       = we_q;
  assign bus.addr_w   = addr_q;
  assign bus.din      = din_q;
  assign busy         = (state == LOAD) || (state == RUN);
  assign done         = (state == DONE);
endmodule
